// File: rtl/shift_cmd_fifo.sv
// Command FIFO that feeds a barrel shifter with {data, select} pairs.
// Circular buffer with registered occupancy; outputs read 0 whenever the FIFO is empty.
module shift_cmd_fifo #(
  parameter int DATA_SIZE = 16,
  parameter int DEPTH     = 4,
  localparam int SEL_W    = $clog2(DATA_SIZE),
  localparam int CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_SIZE-1:0] in_data,
  input  logic [SEL_W-1:0]     in_select,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_SIZE-1:0] data_in,
  output logic [SEL_W-1:0]     select,
  output logic [CNT_W-1:0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENT_W = DATA_SIZE + SEL_W;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop;
  logic [ENT_W-1:0] head;

  assign in_ready  = (count_q != FULL_CNT) && !flush && !rst;
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign count     = count_q;

  assign head    = mem_q[rd_ptr_q];
  assign data_in = out_valid ? head[ENT_W-1:SEL_W] : '0;
  assign select  = out_valid ? head[SEL_W-1:0] : '0;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // control state: pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // storage is never reset; push already excludes rst and flush cycles
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_data, in_select};
  end

endmodule

// File: tb/tb_shift_cmd_fifo.sv
// Bench for shift_cmd_fifo: directed scenarios plus random traffic against a queue model.
module tb_shift_cmd_fifo;

  localparam int DATA_SIZE = 16;
  localparam int DEPTH     = 4;
  localparam int SEL_W     = $clog2(DATA_SIZE);
  localparam int CNT_W     = $clog2(DEPTH) + 1;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 flush = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [DATA_SIZE-1:0] in_data = '0;
  logic [SEL_W-1:0]     in_select = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [DATA_SIZE-1:0] data_in;
  logic [SEL_W-1:0]     select;
  logic [CNT_W-1:0]     count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DATA_SIZE+SEL_W-1:0] sb[$];

  shift_cmd_fifo #(.DATA_SIZE(DATA_SIZE), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_select(in_select),
    .out_valid(out_valid), .out_ready(out_ready), .data_in(data_in), .select(select),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // one clock cycle: drive at negedge, check settled outputs, then update the model at the edge
  task automatic cyc(input bit iv, input logic [DATA_SIZE-1:0] d, input logic [SEL_W-1:0] s,
                     input bit ordy, input bit fl, input bit r);
    bit m_ready, m_valid;
    logic [DATA_SIZE+SEL_W-1:0] head;
    in_valid  = iv;
    in_data   = d;
    in_select = s;
    out_ready = ordy;
    flush     = fl;
    rst       = r;
    #1;
    m_ready = (sb.size() != DEPTH) && !fl && !r;
    m_valid = (sb.size() != 0);
    chk("in_ready", 32'(in_ready), 32'(m_ready));
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("count", 32'(count), 32'(sb.size()));
    if (m_valid) begin
      head = sb[0];
      chk("data_in", 32'(data_in), 32'(head[DATA_SIZE+SEL_W-1:SEL_W]));
      chk("select", 32'(select), 32'(head[SEL_W-1:0]));
    end else begin
      chk("data_in_empty", 32'(data_in), 32'd0);
      chk("select_empty", 32'(select), 32'd0);
    end
    @(posedge clk);
    if (r || fl) begin
      sb.delete();
    end else begin
      if (m_valid && ordy) void'(sb.pop_front());
      if (iv && m_ready) sb.push_back({d, s});
    end
    @(negedge clk);
  endtask

  task automatic idle(input bit ordy);
    cyc(1'b0, '0, '0, ordy, 1'b0, 1'b0);
  endtask

  initial begin
    // bring state out of X before any comparison
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    cyc(1'b1, 16'h1234, 4'd1, 1'b1, 1'b0, 1'b1);  // rst blocks push and pop
    cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);

    // single command
    cyc(1'b1, 16'h1901, 4'd3, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    idle(1'b1);

    // fill to full, fifth push dropped, then drain
    cyc(1'b1, 16'h978B, 4'd2, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 16'h1189, 4'd4, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 16'hD91D, 4'd4, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 16'h0001, 4'd0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 16'hFFFF, 4'd7, 1'b0, 1'b0, 1'b0);
    chk("full_count", 32'(count), 32'(DEPTH));
    repeat (5) idle(1'b1);

    // simultaneous push/pop at count 2
    cyc(1'b1, 16'h0100, 4'd1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 16'h0200, 4'd2, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++)
      cyc(1'b1, 16'(16'h0300 + i), 4'(i), 1'b1, 1'b0, 1'b0);
    chk("steady_count", 32'(count), 32'd2);
    repeat (3) idle(1'b1);

    // full plus pop and in_valid in the same cycle
    for (int i = 0; i < 4; i++)
      cyc(1'b1, 16'(16'hA000 + i), 4'(i + 8), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 16'hBEEF, 4'd5, 1'b1, 1'b0, 1'b0);
    chk("after_full_pop_count", 32'(count), 32'd3);
    chk("after_full_pop_ready", 32'(in_ready), 32'd1);
    repeat (4) idle(1'b1);

    // flush while pushing
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 16'(16'hC000 + i), 4'(i), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 16'hAAAA, 4'd6, 1'b1, 1'b1, 1'b0);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_valid", 32'(out_valid), 32'd0);
    repeat (2) idle(1'b1);

    // reset mid-stream with push/pop active
    cyc(1'b1, 16'hD000, 4'd1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 16'hD001, 4'd2, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 16'hD002, 4'd3, 1'b1, 1'b0, 1'b1);
    chk("rst_count", 32'(count), 32'd0);
    cyc(1'b1, 16'h5555, 4'd1, 1'b0, 1'b0, 1'b0);
    chk("post_rst_head", 32'(data_in), 32'h5555);
    repeat (2) idle(1'b1);

    // random traffic with occasional flush and reset
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 1)), 16'($urandom), 4'($urandom), 1'($urandom_range(0, 2) != 0),
          ($urandom_range(0, 31) == 0), ($urandom_range(0, 63) == 0));
    repeat (6) idle(1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
